// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage.
//   state_e  : controller state encoding (IDLE / BUSY / DONE)
//   CNT_W    : width of the wait-state counter (covers WAIT_CYCLES up to 15)
//   ERR_DATA : value returned on ReadData for a rejected request
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] ERR_DATA = 32'h0;

endpackage

// File: rtl/sram_1rw.sv
// Single-port DEPTH x 32 data array: synchronous write, registered read.
//   CLK   : clock
//   we    : write enable, word written at the rising edge
//   idx   : word index used for both the write and the read
//   wdata : write data
//   rdata : contents of mem[idx] sampled at the previous rising edge
//           (old contents when the same edge also writes idx)
module sram_1rw #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: the array and its read register are deliberately not reset, so the
    // array maps onto RAM macros; contents survive a controller reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage behind the single-cycle MIPS datapath.
// Every valid access stalls the CPU for WAIT_CYCLES cycles and then spends one
// DONE cycle presenting ReadData; stores commit at the edge ending DONE.
//   CLK       : clock, all state updates on the rising edge
//   Reset     : asynchronous, active-low reset
//   MemRead   : load request
//   MemWrite  : store request (wins when both requests are high)
//   Addr      : byte address (AluOut)
//   WriteData : store data
//   ReadData  : load data to the MemToReg mux
//   Stall     : CPU holds PC and suppresses RegWrite while high
//   AddrErr   : sticky misaligned / out-of-range request flag
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AddrErr
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req;
    logic                addr_ok;
    logic                valid_req;
    logic                bad_req;
    logic [ADDR_W-1:0]   addr_idx;
    logic [ADDR_W-1:0]   sram_idx;
    logic                sram_we;
    logic [31:0]         sram_rdata;

    // Requests are masked while Reset is low so Stall and ReadData read as
    // idle immediately, even if the controller keeps MemRead/MemWrite high.
    assign req       = Reset & (MemRead | MemWrite);
    assign addr_ok   = (Addr[1:0] == 2'b00) && (Addr[31:ADDR_W+2] == '0);
    assign valid_req = (state_q == IDLE) && req && addr_ok;
    assign bad_req   = (state_q == IDLE) && req && !addr_ok;
    assign addr_idx  = Addr[ADDR_W+1:2];

    // In IDLE the array is addressed straight from the port so that, with a
    // single wait state, the read register already holds the right word when
    // DONE is entered. Afterwards only the latched index is used.
    assign sram_idx = (state_q == IDLE) ? addr_idx : idx_q;
    assign sram_we  = (state_q == DONE) && wr_q;

    sram_1rw #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .CLK   (CLK),
        .we    (sram_we),
        .idx   (sram_idx),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        Stall    = 1'b0;
        ReadData = rdata_q;
        AddrErr  = err_q | bad_req;

        unique case (state_q)
            IDLE: begin
                if (valid_req) begin
                    Stall   = 1'b1;
                    idx_d   = addr_idx;
                    wdata_d = WriteData;
                    wr_d    = MemWrite;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES > 1) ? BUSY : DONE;
                end else if (bad_req) begin
                    ReadData = ERR_DATA;
                    rdata_d  = ERR_DATA;
                    err_d    = 1'b1;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Read data was captured on entry, before any pending store,
                // which gives read-before-write for combined requests.
                ReadData = sram_rdata;
                rdata_d  = sram_rdata;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= ERR_DATA;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. Three instances cover WAIT_CYCLES = 2, 1
// and 15; each has its own request inputs. A reference model holds the word
// array, the last ReadData value and the sticky error flag per instance, and
// derives the expected Stall/ReadData/AddrErr of every cycle of an access
// from the access rules (WAIT_CYCLES stall cycles, then one DONE cycle).
module tb_dmem_ctrl;

    localparam int NDUT = 3;
    localparam int WAITS [NDUT] = '{2, 1, 15};

    logic        CLK = 1'b0;
    logic        Reset;
    logic        mem_read  [NDUT];
    logic        mem_write [NDUT];
    logic [31:0] addr      [NDUT];
    logic [31:0] wdata     [NDUT];
    logic [31:0] rdata     [NDUT];
    logic        stall     [NDUT];
    logic        aerr      [NDUT];

    // reference model
    logic [31:0] model_mem   [NDUT][256];
    bit          model_known [NDUT][256];
    logic [31:0] model_hold  [NDUT];
    logic        model_err   [NDUT];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_ctrl #(
            .DEPTH       (256),
            .ADDR_W      (8),
            .WAIT_CYCLES (WAITS[g])
        ) u_dut (
            .CLK       (CLK),
            .Reset     (Reset),
            .MemRead   (mem_read[g]),
            .MemWrite  (mem_write[g]),
            .Addr      (addr[g]),
            .WriteData (wdata[g]),
            .ReadData  (rdata[g]),
            .Stall     (stall[g]),
            .AddrErr   (aerr[g])
        );
    end

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int d, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] w);
        mem_read[d]  = rd;
        mem_write[d] = wr;
        addr[d]      = a;
        wdata[d]     = w;
    endtask

    task automatic set_random(input int d);
        set_req(d, 1'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            model_hold[d] = 32'h0;
            model_err[d]  = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after a later rising edge
    // with the instance's inputs idle.
    task automatic idle_check(input int d);
        set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        check($sformatf("d%0d idle Stall", d), 32'(stall[d]), 32'h0);
        check($sformatf("d%0d idle ReadData", d), rdata[d], model_hold[d]);
        check($sformatf("d%0d idle AddrErr", d), 32'(aerr[d]), 32'(model_err[d]));
        @(posedge CLK); #1;
    endtask

    task automatic access(input int d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] w);
        logic        ok;
        logic [7:0]  ix;
        logic [31:0] old;
        bit          known;
        ok    = (rd | wr) && (a[1:0] == 2'b00) && (a[31:10] == 22'h0);
        ix    = a[9:2];
        set_req(d, rd, wr, a, w);
        @(negedge CLK);
        if (!ok) begin
            model_err[d]  = 1'b1;
            model_hold[d] = 32'h0;
            check($sformatf("d%0d bad Stall a=%h", d, a), 32'(stall[d]), 32'h0);
            check($sformatf("d%0d bad ReadData a=%h", d, a), rdata[d], 32'h0);
            check($sformatf("d%0d bad AddrErr a=%h", d, a), 32'(aerr[d]), 32'h1);
            @(posedge CLK); #1;
        end else begin
            old   = model_mem[d][ix];
            known = model_known[d][ix];
            check($sformatf("d%0d c0 Stall", d), 32'(stall[d]), 32'h1);
            check($sformatf("d%0d c0 AddrErr", d), 32'(aerr[d]), 32'(model_err[d]));
            for (int c = 1; c < WAITS[d]; c++) begin
                @(posedge CLK); #1;
                set_random(d);
                @(negedge CLK);
                check($sformatf("d%0d c%0d Stall", d, c), 32'(stall[d]), 32'h1);
                check($sformatf("d%0d c%0d AddrErr", d, c), 32'(aerr[d]), 32'(model_err[d]));
            end
            @(posedge CLK); #1;
            set_random(d);
            @(negedge CLK);
            check($sformatf("d%0d done Stall", d), 32'(stall[d]), 32'h0);
            check($sformatf("d%0d done AddrErr", d), 32'(aerr[d]), 32'(model_err[d]));
            if (known) begin
                check($sformatf("d%0d done ReadData a=%h", d, a), rdata[d], old);
            end
            model_hold[d] = known ? old : rdata[d];
            if (wr) begin
                model_mem[d][ix]   = w;
                model_known[d][ix] = 1'b1;
            end
            @(posedge CLK); #1;
            set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          d;
        int          sel;

        Reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
            for (int j = 0; j < 256; j++) model_known[i][j] = 1'b0;
        end
        model_reset();
        #2 Reset = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("d%0d reset Stall", i), 32'(stall[i]), 32'h0);
            check($sformatf("d%0d reset ReadData", i), rdata[i], 32'h0);
            check($sformatf("d%0d reset AddrErr", i), 32'(aerr[i]), 32'h0);
        end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        Reset = 1'b1;

        // initialise every word of every instance through the port
        for (int i = 0; i < NDUT; i++)
            for (int j = 0; j < 256; j++)
                access(i, 1'b0, 1'b1, 32'(j) << 2, $urandom);

        // wait-2 store then load
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        check("d0 load DEADBEEF", model_hold[0], 32'hDEADBEEF);
        idle_check(0);

        // wait-1 back-to-back store then load
        access(1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0);
        check("d1 load A5A5A5A5", model_hold[1], 32'hA5A5A5A5);

        // combined read+write is a store with read-before-write
        access(0, 1'b0, 1'b1, 32'h20, 32'h11);
        access(0, 1'b1, 1'b1, 32'h20, 32'h22);
        check("d0 rmw old", model_hold[0], 32'h11);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("d0 rmw new", model_hold[0], 32'h22);

        // misaligned read, out-of-range write, sticky flag, recovery
        access(0, 1'b1, 1'b0, 32'h6, 32'h0);
        access(0, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF);
        idle_check(0);
        idle_check(0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);

        // wait-15 load with inputs toggling during BUSY
        access(2, 1'b1, 1'b0, 32'h3FC, 32'h0);
        idle_check(2);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            d   = $urandom_range(0, NDUT - 1);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                idle_check(d);
            end else if (sel == 1) begin
                a = $urandom;
                if ($urandom_range(0, 1) == 0) a = (a & 32'h3FC) | 32'($urandom_range(1, 3));
                else if (a[31:10] == 22'h0) a[31] = 1'b1;
                access(d, 1'($urandom), 1'b1, a, $urandom);
            end else begin
                a = {22'h0, 8'($urandom), 2'b00};
                case ($urandom_range(0, 2))
                    0:       access(d, 1'b1, 1'b0, a, $urandom);
                    1:       access(d, 1'b0, 1'b1, a, $urandom);
                    default: access(d, 1'b1, 1'b1, a, $urandom);
                endcase
            end
        end

        // reset in the middle of a store aborts it
        access(0, 1'b0, 1'b1, 32'h8, 32'h55);
        access(0, 1'b0, 1'b1, 32'h404, 32'h0);
        set_req(0, 1'b0, 1'b1, 32'h8, 32'h1234);
        @(negedge CLK);
        check("d0 abort c0 Stall", 32'(stall[0]), 32'h1);
        @(posedge CLK); #1;
        Reset = 1'b0;
        #1;
        check("d0 abort reset Stall", 32'(stall[0]), 32'h0);
        check("d0 abort reset ReadData", rdata[0], 32'h0);
        check("d0 abort reset AddrErr", 32'(aerr[0]), 32'h0);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        Reset = 1'b1;
        model_reset();
        idle_check(0);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);
        check("d0 aborted store", model_hold[0], 32'h55);
        idle_check(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
